// File: rtl/multicycle_control_if.sv
// Bundle of control-sequencer signals between the multicycle controller and
// the datapath, memory and register file around it.
//   master : the controller. It takes instr/mem_ready/alu_zero in and drives
//            the strobes, selects, rf addresses, illegal_op and state.
//   slave  : the datapath/memory side, with the opposite directions.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [4:0]  rf_read_address_0;
    logic [4:0]  rf_read_address_1;
    logic [4:0]  rf_write_address;
    logic        rf_write_en;
    logic        rf_wdata_sel;
    logic        illegal_op;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready, alu_zero,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, rf_read_address_0,
               rf_read_address_1, rf_write_address, rf_write_en,
               rf_wdata_sel, illegal_op, state
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, rf_read_address_0,
               rf_read_address_1, rf_write_address, rf_write_en,
               rf_wdata_sel, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer. It holds the instruction register and
// steps each instruction through FETCH/DECODE/EXEC/MEM/WB, with HALT on an
// unsupported opcode. It drives the register-file addresses and write strobe,
// plus the ALU, PC and memory controls.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset. It aborts any instruction in
//          flight and forces every strobe low while it is held.
//   bus  - multicycle_control_if.master (memory handshake, datapath
//          controls, rf addresses, illegal_op, state)
module multicycle_control #(
    parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    logic        is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_j_s;
    logic        funct_ok_s, legal_s;
    logic [3:0]  funct_alu_op_s;
    logic [4:0]  rf_waddr_s;
    logic        unused_ir_bits_s;

    logic        mem_req_s, mem_we_s, mem_addr_sel_s, ir_we_s, pc_we_s;
    logic [1:0]  pc_src_s, alu_src_b_s;
    logic        alu_src_a_s, rf_write_en_s, rf_wdata_sel_s;
    logic [3:0]  alu_op_s;

    assign is_r_s    = (ir_q[31:26] == OP_RTYPE);
    assign is_addi_s = (ir_q[31:26] == OP_ADDI);
    assign is_lw_s   = (ir_q[31:26] == OP_LW);
    assign is_sw_s   = (ir_q[31:26] == OP_SW);
    assign is_beq_s  = (ir_q[31:26] == OP_BEQ);
    assign is_j_s    = (ir_q[31:26] == OP_J);
    assign legal_s   = (is_r_s & funct_ok_s) | is_addi_s | is_lw_s | is_sw_s
                     | is_beq_s | is_j_s;
    // Shift amount is a datapath concern; the controller never looks at it.
    assign unused_ir_bits_s = ^ir_q[10:6];

    // R-type funct decode: legality and ALU operation
    always_comb begin
        funct_ok_s     = 1'b1;
        funct_alu_op_s = ALU_ADD;
        case (ir_q[5:0])
            6'h20:   funct_alu_op_s = ALU_ADD;
            6'h22:   funct_alu_op_s = ALU_SUB;
            6'h24:   funct_alu_op_s = ALU_AND;
            6'h25:   funct_alu_op_s = ALU_OR;
            6'h2A:   funct_alu_op_s = ALU_SLT;
            default: funct_ok_s     = 1'b0;
        endcase
    end

    // Destination register: rd for R-type, rt for ADDI/LW, r0 (no write) otherwise
    always_comb begin
        rf_waddr_s = 5'd0;
        if (is_r_s) begin
            rf_waddr_s = ir_q[15:11];
        end else if (is_addi_s || is_lw_s) begin
            rf_waddr_s = ir_q[20:16];
        end else begin
            rf_waddr_s = 5'd0;
        end
    end

    // Next-state and control outputs (Moore, plus mem_ready/alu_zero/opcode terms)
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        illegal_d      = illegal_q;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_we_s        = 1'b0;
        pc_we_s        = 1'b0;
        pc_src_s       = 2'b00;
        alu_src_a_s    = 1'b0;
        alu_src_b_s    = 2'b00;
        alu_op_s       = ALU_ADD;
        rf_write_en_s  = 1'b0;
        rf_wdata_sel_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                if (bus.mem_ready) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is latched into ALU-out here
                alu_src_b_s = 2'b11;
                if (legal_s) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_r_s) begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = funct_alu_op_s;
                    state_d     = S_WB;
                end else if (is_addi_s || is_lw_s || is_sw_s) begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                    state_d     = is_addi_s ? S_WB : S_MEM;
                end else if (is_beq_s) begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = ALU_SUB;
                    pc_src_s    = 2'b01;
                    pc_we_s     = bus.alu_zero;
                    state_d     = S_FETCH;
                end else if (is_j_s) begin
                    pc_we_s  = 1'b1;
                    pc_src_s = 2'b10;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                mem_we_s       = is_sw_s;
                if (bus.mem_ready) begin
                    state_d = is_lw_s ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_wdata_sel_s = is_lw_s;
                rf_write_en_s  = (rf_waddr_s != 5'd0);
                state_d        = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= RESET_IR;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are gated by rst so nothing fires while reset is held
    assign bus.mem_req           = mem_req_s & ~rst;
    assign bus.mem_we            = mem_we_s & ~rst;
    assign bus.ir_we             = ir_we_s & ~rst;
    assign bus.pc_we             = pc_we_s & ~rst;
    assign bus.rf_write_en       = rf_write_en_s & ~rst;
    assign bus.mem_addr_sel      = mem_addr_sel_s;
    assign bus.pc_src            = pc_src_s;
    assign bus.alu_src_a         = alu_src_a_s;
    assign bus.alu_src_b         = alu_src_b_s;
    assign bus.alu_op            = alu_op_s;
    assign bus.rf_wdata_sel      = rf_wdata_sel_s;
    assign bus.rf_read_address_0 = ir_q[25:21];
    assign bus.rf_read_address_1 = ir_q[20:16];
    assign bus.rf_write_address  = rf_waddr_s;
    assign bus.illegal_op        = illegal_q;
    assign bus.state             = state_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control sequencer for the multicycle CPU, directly upstream of the register file.
- Holds the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the register file read/write addresses and write enable, plus ALU, PC and memory strobes.
- Memory accesses use a req/ready handshake, so memory latency is variable.

Parameters:
- RESET_IR, 32'h0000_0000, instruction register value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  memory read data; captured as the instruction during FETCH
- mem_ready  in  1  memory completed the current request this cycle
- alu_zero  in  1  ALU result is zero (BEQ compare)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write (SW only)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result register
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC load strobe
- pc_src  out  2  00 = ALU (PC+4), 01 = ALU-out register (branch target), 10 = jump target {PC[31:28], IR[25:0], 2'b00}
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT
- rf_read_address_0  out  5  IR[25:21] (rs)
- rf_read_address_1  out  5  IR[20:16] (rt)
- rf_write_address  out  5  IR[15:11] (rd) for R-type; IR[20:16] (rt) for ADDI/LW; 0 otherwise
- rf_write_en  out  1  register file write strobe, one cycle
- rf_wdata_sel  out  1  0 = ALU-out register, 1 = memory data register
- illegal_op  out  1  sticky; unsupported opcode/funct seen
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7

Behaviour:
Reset:
- rst=1 at a clk edge: state=FETCH, IR=RESET_IR, illegal_op=0.
- While rst=1, all strobes (mem_req, mem_we, ir_we, pc_we, rf_write_en) are forced 0.
- Reset in any state, including mid-MEM with a request outstanding, aborts the instruction; no rf/pc/ir write occurs.

Outputs:
- Moore outputs from state, except where mem_ready, alu_zero or the opcode is named below.
- rf read/write addresses decode combinationally from IR at all times.

ISA, opcode IR[31:26]:
- 0x00 R-type, funct IR[5:0]: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
- 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J.

State transitions:
- FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - mem_ready=0: stay in FETCH, all strobes 0.
  - mem_ready=1: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- DECODE: one cycle; alu_src_a=0, alu_src_b=11, ADD (branch target latched in ALU-out).
  - Legal opcode/funct: go to EXEC.
  - Otherwise: illegal_op<=1, go to HALT.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op from funct, then WB.
  - ADDI/LW/SW: alu_src_a=1, alu_src_b=10, ADD; ADDI goes to WB, LW/SW go to MEM.
  - BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=alu_zero, then FETCH.
  - J: pc_we=1, pc_src=10, then FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(SW).
  - Wait for mem_ready.
  - On ready: LW goes to WB, SW goes to FETCH.
- WB: rf_wdata_sel=(LW); rf_write_en=1 unless rf_write_address==0 (r0 write suppressed); then FETCH.
- HALT: all strobes 0; held until rst.

Latency with zero-wait memory (mem_ready=1 on first request cycle):
- R-type/ADDI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BEQ: 3 cycles.
- J: 3 cycles.
- Each wait cycle on mem_ready adds one cycle.

Invariants:
- rf_write_en and pc_we never assert in the same cycle as mem_req without mem_ready.
- ir_we asserts only in FETCH.

Test Plan:
- Reset, then instr=ADD r3,r1,r2 (0x00221820), mem_ready=1 -> states 0,1,2,4; ir_we+pc_we in cycle 1; rf_read_address_0/1=1/2; rf_write_address=3, rf_write_en=1 for exactly one cycle in cycle 4; alu_op=0000.
- LW r5,8(r1) (0x8C250008), mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, mem_we=0; WB writes addr 5 with rf_wdata_sel=1; total 8 cycles.
- SW r5,4(r1) (0xAC250004) -> mem_we=1 in MEM; rf_write_en never asserts; returns to FETCH after 4 cycles.
- BEQ (0x10220003) with alu_zero=1 then alu_zero=0 -> pc_we=1/pc_src=01 in EXEC for the first case; pc_we=0 for the second; both back to FETCH after 3 cycles.
- ADDI r0,r1,5 (0x20200005) -> rf_write_address=0, rf_write_en stays 0 in WB.
- Opcode 0x3F, then assert rst for 1 cycle mid-MEM of a following LW -> illegal_op=1 and state=7 held; after rst: state=0, illegal_op=0, no rf_write_en.
